// File: rtl/ashift_seq_ctrl.sv
// Sequenced 32-bit arithmetic shifter, one position per clock.
// Optional sticky left-shift overflow flag: define ASHIFT_SEQ_OVF_EN.
module ashift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] d_in,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] cnt;
  logic             dir_q;

`ifdef ASHIFT_SEQ_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
`ifdef ASHIFT_SEQ_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= d_in;
            cnt   <= amt;
            dir_q <= dir;
`ifdef ASHIFT_SEQ_OVF_EN
            ovf_q <= 1'b0;
`endif
            state <= (amt == '0) ? DONE : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (dir_q) begin
            acc <= {acc[WIDTH-1], acc[WIDTH-1:1]};
          end else begin
            acc <= {acc[WIDTH-2:0], 1'b0};
`ifdef ASHIFT_SEQ_OVF_EN
            // a bit unlike the result sign is about to leave the top
            if (acc[WIDTH-1] != acc[WIDTH-2]) ovf_q <= 1'b1;
`endif
          end
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign result = acc;

`ifdef ASHIFT_SEQ_OVF_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ashift_seq_ctrl.sv
// Bench for ashift_seq_ctrl: vector table, hand sequences, random ops.
// Overflow expectations follow ASHIFT_SEQ_OVF_EN.
module tb_ashift_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [31:0] d_in;
  logic [4:0]  amt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ashift_seq_ctrl #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .d_in(d_in), .amt(amt), .busy(busy), .done(done),
    .result(result), .ovf(ovf)
  );

  typedef struct {
    string       name;
    logic        dir;
    logic [31:0] d;
    int          amt;
    logic [31:0] res;
    logic        ovf_en;
  } vec_t;

  function automatic logic [31:0] m_res(logic dr, logic [31:0] d, int a);
    logic signed [31:0] s;
    s = $signed(d);
    if (dr) return 32'(s >>> a);
    return d << a;
  endfunction

  // Overflow iff the value does not survive a left shift as a signed number
  function automatic logic m_ovf(logic dr, logic [31:0] d, int a);
    logic signed [31:0] sh;
`ifdef ASHIFT_SEQ_OVF_EN
    if (dr) return 1'b0;
    sh = $signed(d << a);
    return (sh >>> a) != $signed(d);
`else
    sh = '0;
    return 1'b0;
`endif
  endfunction

  function automatic logic eff_ovf(logic o);
`ifdef ASHIFT_SEQ_OVF_EN
    return o;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input string nm, input logic dr,
                       input logic [31:0] d, input int a,
                       input logic [31:0] er, input logic eo);
    int k;
    int nb;
    k  = 1;
    nb = 0;
    @(negedge clk);
    start = 1'b1;
    dir   = dr;
    d_in  = d;
    amt   = a[4:0];
    @(negedge clk);
    start = 1'b0;
    dir   = ~dr;
    d_in  = ~d;
    amt   = 5'($urandom);
    while (!done && k < 40) begin
      if (busy) nb++;
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, a + 1);
    chk({nm, " busy_cycles"}, nb, a);
    chk({nm, " result"}, result, er);
    chk({nm, " ovf"}, {31'b0, ovf}, {31'b0, eo});
    @(negedge clk);
    chk({nm, " done_pulse"}, {31'b0, done}, 32'd0);
    chk({nm, " held"}, result, er);
  endtask

  vec_t tbl[5];

  initial begin
    int k;
    int nd;
    logic        rd;
    logic [31:0] rv;
    int          ra;

    tbl[0] = '{"shl4", 1'b0, 32'h0000_0001, 4, 32'h0000_0010, 1'b0};
    tbl[1] = '{"asr31", 1'b1, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0};
    tbl[2] = '{"asr1", 1'b1, 32'h3232_3232, 1, 32'h1919_1919, 1'b0};
    tbl[3] = '{"amt0", 1'b0, 32'h9696_9696, 0, 32'h9696_9696, 1'b0};
    tbl[4] = '{"ovf1", 1'b0, 32'h4000_0000, 1, 32'h8000_0000, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    dir   = 1'b0;
    d_in  = '0;
    amt   = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst ovf", {31'b0, ovf}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      do_op(tbl[i].name, tbl[i].dir, tbl[i].d, tbl[i].amt,
            tbl[i].res, eff_ovf(tbl[i].ovf_en));

    // Back-to-back: new start while DONE is showing
    @(negedge clk);
    start = 1'b1; dir = 1'b0; d_in = 32'h9696_9696; amt = 5'd0;
    @(negedge clk);
    chk("b2b first done", {31'b0, done}, 32'd1);
    chk("b2b first result", result, 32'h9696_9696);
    d_in = 32'h0000_0001; amt = 5'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b reload", result, 32'h0000_0001);
    chk("b2b busy", {31'b0, busy}, 32'd1);
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b latency", k, 3);
    chk("b2b result", result, 32'h0000_0004);

    // Start pulsed mid-SHIFT is ignored
    @(negedge clk);
    start = 1'b1; dir = 1'b0; d_in = 32'h1234_5678; amt = 5'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; d_in = 32'hFFFF_FFFF; amt = 5'd1;
    @(negedge clk);
    start = 1'b0;
    k = 3;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ign latency", k, 7);
    chk("ign result", result, 32'h8D15_9E00);

    // Reset in cycle 3 of a 10-step shift
    @(negedge clk);
    start = 1'b1; dir = 1'b0; d_in = 32'h0000_ABCD; amt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst ovf", {31'b0, ovf}, 32'd0);
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst no_done", nd, 0);

    // Reset wins over start on the same edge
    start = 1'b1; reset = 1'b1; d_in = 32'h5555_5555; amt = 5'd0;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("rst_prio result", result, 32'd0);
    chk("rst_prio done", {31'b0, done}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      rd = 1'($urandom);
      rv = $urandom;
      ra = int'($urandom_range(0, 31));
      if (i % 4 == 0) rv = rv >> ($urandom_range(0, 31));
      do_op("rand", rd, rv, ra, m_res(rd, rv, ra), m_ovf(rd, rv, ra));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ashift_seq_ctrl.md
# ashift_seq_ctrl

Multi-cycle controller that sequences a 32-bit single-position arithmetic shift datapath to perform shifts of 0–31 positions, one position per clock. It sits between the ALU decode and the ALU result mux. It accepts a request via a start/busy/done handshake and holds the result until the next accepted request.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `AMT_W`, 5: shift-amount width.

Ports:
- `clk` in, 1: single clock; all state changes on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `start` in, 1: request strobe; sampled only when not busy.
- `dir` in, 1: 0 = shift left (zero fill); 1 = arithmetic shift right (sign fill).
- `d_in` in, 32: operand, sampled with `start`.
- `amt` in, 5: shift count 0–31, sampled with `start`.
- `busy` out, 1: high while in SHIFT.
- `done` out, 1: one-cycle pulse; `result` is valid from this cycle on.
- `result` out, 32: shifted value, held until the next accepted `start`.
- `ovf` out, 1: sticky left-shift overflow flag (see Configuration).

## Operation
- States are IDLE, SHIFT and DONE. Internal registers are `acc[31:0]`, `cnt[4:0]`, `dir_q` and `ovf_q`.
- Acceptance: `start`=1 while the state is IDLE or DONE.
  - On acceptance: `acc`<=`d_in`, `cnt`<=`amt`, `dir_q`<=`dir`, `ovf_q`<=0.
  - Next state is DONE if `amt`==0, else SHIFT.
- SHIFT, each edge:
  - Left: `acc`<={`acc[30:0]`,0}.
  - Right: `acc`<={`acc[31]`,`acc[31:1]`}.
  - `cnt`<=`cnt`-1.
  - Goes to DONE when `cnt`==1, otherwise stays in SHIFT.
- DONE: `done`=1 for exactly one cycle. Next state is IDLE, unless `start` is accepted, which re-enters SHIFT or DONE directly (back-to-back operation).
- `start` while in SHIFT is ignored: no queuing, no effect on the running operation.
- `result` is always `acc`.
- Outputs are decoded from state: `busy` = (state==SHIFT); `done` = (state==DONE).
- `dir` and `d_in` changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `acc`=0, `cnt`=0, `ovf_q`=0; therefore `busy`=0, `done`=0, `result`=0x00000000, `ovf`=0.
- With `start` sampled at edge E0, `done` is high in the cycle following edge E0+`amt`. That is `amt`+1 cycles after the start cycle: `amt`=0 gives 1 cycle, `amt`=31 gives 32 cycles.
- `busy` is high for exactly `amt` cycles per operation.
- Reset asserted mid-operation: on the next edge, return to IDLE with all registers at reset values. The in-flight operation is discarded and no `done` pulse is produced.
- `reset` takes priority over `start` on the same edge.
- Simultaneous `start` and DONE: `done` is still 1 in that cycle. The new operation's `result` replaces the old one at the next edge.

## Configuration
- Macro: `ASHIFT_SEQ_OVF_EN`.
- Defined:
  - In SHIFT with `dir_q`=0, `ovf_q` is set sticky if `acc[31]`!=`acc[30]` before the step. This means a bit that differs from the result sign was shifted out.
  - `ovf_q` is cleared on acceptance and by `reset`.
  - Right shifts never set it.
  - `ovf`=`ovf_q`.
- Undefined: the `ovf` port remains but is tied to 0. The overflow logic is not synthesized.

## Test plan
- Reset with `reset`=1 for 2 cycles -> `busy`=0, `done`=0, `result`=0x00000000, `ovf`=0.
- `dir`=0, `d_in`=0x00000001, `amt`=4 -> `busy` high 4 cycles; `done` in cycle 5; `result`=0x00000010; `ovf`=0.
- `dir`=1, `d_in`=0x80000000, `amt`=31 -> `done` in cycle 32; `result`=0xFFFFFFFF. Then `dir`=1, `d_in`=0x32323232, `amt`=1 -> `result`=0x19191919.
- `amt`=0, `d_in`=0x96969696 -> no `busy`; `done` in cycle 1; `result`=0x96969696. A back-to-back `start` during DONE with `d_in`=0x1, `amt`=2 -> `done` 3 cycles later; `result`=0x4.
- `start` pulsed again during SHIFT with different `d_in` -> ignored, original result produced. `reset` at cycle 3 of an `amt`=10 shift -> IDLE, `result`=0, no `done`.
- With the macro defined: `dir`=0, `d_in`=0x40000000, `amt`=1 -> `result`=0x80000000, `ovf`=1. Without the macro -> same `result`, `ovf`=0.
